// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-stage definitions: opcodes, ALUOp and ALU control codes, EX/MEM record.
// Honours LEGV8_MUL_EN: when undefined, the MUL opcode decodes as unsupported.
package legv8_pkg;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100000;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_PASS_B = 2'b01,
    ALUOP_RTYPE  = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_SUB    = 4'b0110,
    ALU_PASS_B = 4'b0111,
    ALU_MUL    = 4'b1000,
    ALU_NONE   = 4'b1111
  } alu_ctrl_e;

  typedef enum logic {
    MULT_IDLE,
    MULT_BUSY
  } mult_state_e;

  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [63:0] branch_target;
    logic [63:0] alu_result;
    logic        zero;
    logic [63:0] store_data;
    logic [4:0]  dest;
  } exmem_t;

  // ALU_NONE forces a zero result for anything the stage does not implement.
  function automatic alu_ctrl_e alu_control(input logic [1:0] alu_op, input logic [10:0] opcode);
    alu_control = ALU_NONE;
    case (alu_op)
      ALUOP_ADD:    alu_control = ALU_ADD;
      ALUOP_PASS_B: alu_control = ALU_PASS_B;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: alu_control = ALU_ADD;
          OPC_SUB: alu_control = ALU_SUB;
          OPC_AND: alu_control = ALU_AND;
          OPC_ORR: alu_control = ALU_OR;
`ifdef LEGV8_MUL_EN
          OPC_MUL: alu_control = ALU_MUL;
`endif
          default: alu_control = ALU_NONE;
        endcase
      end
      default: alu_control = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/legv8_execute_stage_if.sv
// ID/EX inputs, EX/MEM outputs and the upstream stall of the LEGv8 execute stage.
interface legv8_execute_stage_if;
  logic [1:0]  ALUOp_s3;
  logic        ALUSrc_s3, MemtoReg_s3, RegWrite_s3, MemRead_s3, MemWrite_s3, Branch_s3;
  logic [63:0] PC_s3, RD1_s3, RD2_s3, SE1out_s3;
  logic [10:0] Opcode_s3;
  logic [4:0]  Ins4_0_s3;

  logic        MemtoReg_s4, RegWrite_s4, MemRead_s4, MemWrite_s4, Branch_s4;
  logic [63:0] BranchTarget_s4, ALUResult_s4, RD2_s4;
  logic        Zero_s4;
  logic [4:0]  Ins4_0_s4;
  logic        stall;

  modport master (
    output ALUOp_s3, ALUSrc_s3, MemtoReg_s3, RegWrite_s3, MemRead_s3, MemWrite_s3, Branch_s3,
           PC_s3, RD1_s3, RD2_s3, SE1out_s3, Opcode_s3, Ins4_0_s3,
    input  MemtoReg_s4, RegWrite_s4, MemRead_s4, MemWrite_s4, Branch_s4,
           BranchTarget_s4, ALUResult_s4, Zero_s4, RD2_s4, Ins4_0_s4, stall
  );

  modport slave (
    input  ALUOp_s3, ALUSrc_s3, MemtoReg_s3, RegWrite_s3, MemRead_s3, MemWrite_s3, Branch_s3,
           PC_s3, RD1_s3, RD2_s3, SE1out_s3, Opcode_s3, Ins4_0_s3,
    output MemtoReg_s4, RegWrite_s4, MemRead_s4, MemWrite_s4, Branch_s4,
           BranchTarget_s4, ALUResult_s4, Zero_s4, RD2_s4, Ins4_0_s4, stall
  );
endinterface

// File: rtl/legv8_seq_multiplier.sv
// Radix-2 shift-add 64x64 multiplier (low 64 bits), one multiplier bit per cycle.
// Only compiled when LEGV8_MUL_EN is defined.
`ifdef LEGV8_MUL_EN
module legv8_seq_multiplier
  import legv8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  mult_state_e state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] acc_next;

  // acc_next already folds in the current bit, so at count 63 it is the full product.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign busy     = (state_q == MULT_BUSY);
  assign done     = busy && (count_q == 6'd63);
  assign product  = acc_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MULT_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      MULT_IDLE: begin
        if (start) begin
          state_d  = MULT_BUSY;
          count_d  = '0;
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          acc_d    = '0;
        end
      end
      MULT_BUSY: begin
        acc_d    = acc_next;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[63:1]};
        count_d  = count_q + 6'd1;
        if (count_q == 6'd63) state_d = MULT_IDLE;
      end
      default: state_d = MULT_IDLE;
    endcase
  end
endmodule
`endif

// File: rtl/legv8_execute_stage.sv
// LEGv8 execute stage: ALU decode, operand select, branch target and the EX/MEM register.
// Define LEGV8_MUL_EN to build in the iterative multiplier and its upstream stall.
module legv8_execute_stage
  import legv8_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  legv8_execute_stage_if.slave ex
);
  alu_ctrl_e   alu_ctrl;
  logic [63:0] operand_b;
  logic [63:0] alu_result;
  exmem_t      issue;
  exmem_t      exmem_d;
  exmem_t      exmem_q;

  assign alu_ctrl  = alu_control(ex.ALUOp_s3, ex.Opcode_s3);
  assign operand_b = ex.ALUSrc_s3 ? ex.SE1out_s3 : ex.RD2_s3;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD:    alu_result = ex.RD1_s3 + operand_b;
      ALU_SUB:    alu_result = ex.RD1_s3 - operand_b;
      ALU_AND:    alu_result = ex.RD1_s3 & operand_b;
      ALU_OR:     alu_result = ex.RD1_s3 | operand_b;
      ALU_PASS_B: alu_result = operand_b;
      default:    alu_result = '0;
    endcase
  end

  always_comb begin
    issue               = '0;
    issue.mem_to_reg    = ex.MemtoReg_s3;
    issue.reg_write     = ex.RegWrite_s3;
    issue.mem_read      = ex.MemRead_s3;
    issue.mem_write     = ex.MemWrite_s3;
    issue.branch        = ex.Branch_s3;
    issue.branch_target = ex.PC_s3 + (ex.SE1out_s3 << 2);
    issue.alu_result    = alu_result;
    issue.zero          = (alu_result == 64'd0);
    issue.store_data    = ex.RD2_s3;
    issue.dest          = ex.Ins4_0_s3;
  end

`ifdef LEGV8_MUL_EN
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_product;
  exmem_t      held_q;

  assign mul_start = !mul_busy && (alu_ctrl == ALU_MUL);
  assign ex.stall  = mul_start || (mul_busy && !mul_done);

  legv8_seq_multiplier u_mul (
    .clock        (clock),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (ex.RD1_s3),
    .multiplier   (operand_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  // Control bits and store data ride alongside the multiply so BUSY never looks at ID/EX.
  always_ff @(posedge clock) begin
    if (reset) held_q <= '0;
    else if (mul_start) held_q <= issue;
  end

  always_comb begin
    exmem_d = issue;
    if (mul_done) begin
      exmem_d            = held_q;
      exmem_d.alu_result = mul_product;
      exmem_d.zero       = (mul_product == 64'd0);
    end else if (ex.stall) begin
      exmem_d = '0;
    end
  end
`else
  assign ex.stall = 1'b0;

  always_comb begin
    exmem_d = issue;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) exmem_q <= '0;
    else exmem_q <= exmem_d;
  end

  assign ex.MemtoReg_s4     = exmem_q.mem_to_reg;
  assign ex.RegWrite_s4     = exmem_q.reg_write;
  assign ex.MemRead_s4      = exmem_q.mem_read;
  assign ex.MemWrite_s4     = exmem_q.mem_write;
  assign ex.Branch_s4       = exmem_q.branch;
  assign ex.BranchTarget_s4 = exmem_q.branch_target;
  assign ex.ALUResult_s4    = exmem_q.alu_result;
  assign ex.Zero_s4         = exmem_q.zero;
  assign ex.RD2_s4          = exmem_q.store_data;
  assign ex.Ins4_0_s4       = exmem_q.dest;
endmodule

// File: tb/tb_legv8_execute_stage.sv
// Bench for legv8_execute_stage: directed LEGv8 cases plus randomized ALU ops against a reference model.
// MUL expectations follow LEGV8_MUL_EN (multi-cycle when defined, unsupported opcode otherwise).
module tb_legv8_execute_stage;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  legv8_execute_stage_if ex ();

  legv8_execute_stage dut (
    .clock (clock),
    .reset (reset),
    .ex    (ex)
  );

  always #5 clock = ~clock;

`ifdef LEGV8_MUL_EN
  localparam bit MulEnabled = 1'b1;
`else
  localparam bit MulEnabled = 1'b0;
`endif

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpMul  = 11'b10011011000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpCbz  = 11'b10110100000;

  // ctrl packs {MemtoReg, RegWrite, MemRead, MemWrite, Branch}.
  typedef struct {
    logic [1:0]  aluOp;
    logic        aluSrc;
    logic [4:0]  ctrl;
    logic [63:0] pc, rd1, rd2, se;
    logic [10:0] opcode;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    logic [4:0]  ctrl;
    logic [63:0] target, result, storeData;
    logic        zero;
    logic [4:0]  rd;
  } expect_t;

  function automatic stim_t makeStim(input logic [1:0] aluOp, input logic aluSrc, input logic [4:0] ctrl,
                                     input logic [63:0] pc, input logic [63:0] rd1, input logic [63:0] rd2,
                                     input logic [63:0] se, input logic [10:0] opcode, input logic [4:0] rd);
    stim_t s;
    s.aluOp = aluOp; s.aluSrc = aluSrc; s.ctrl = ctrl; s.pc = pc; s.rd1 = rd1;
    s.rd2 = rd2; s.se = se; s.opcode = opcode; s.rd = rd;
    return s;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic expect_t refModel(input stim_t s);
    expect_t     e;
    logic [63:0] b;
    logic [63:0] r;
    b = s.aluSrc ? s.se : s.rd2;
    r = 64'd0;
    if (s.aluOp == 2'b00) r = s.rd1 + b;
    else if (s.aluOp == 2'b01) r = b;
    else if (s.aluOp == 2'b10) begin
      if (s.opcode == OpAdd) r = s.rd1 + b;
      else if (s.opcode == OpSub) r = s.rd1 - b;
      else if (s.opcode == OpAnd) r = s.rd1 & b;
      else if (s.opcode == OpOrr) r = s.rd1 | b;
      else if (s.opcode == OpMul && MulEnabled) r = s.rd1 * b;
    end
    e.ctrl      = s.ctrl;
    e.target    = s.pc + s.se * 64'd4;
    e.result    = r;
    e.zero      = (r == 64'd0);
    e.storeData = s.rd2;
    e.rd        = s.rd;
    return e;
  endfunction

  function automatic expect_t bubble();
    expect_t e;
    e.ctrl = '0; e.target = '0; e.result = '0; e.storeData = '0; e.zero = 1'b0; e.rd = '0;
    return e;
  endfunction

  function automatic stim_t randomStim();
    stim_t s;
    logic [10:0] ops [7];
    ops = '{OpAdd, OpSub, OpAnd, OpOrr, OpMul, OpLdur, OpCbz};
    s.aluOp  = 2'($urandom_range(0, 3));
    s.aluSrc = 1'($urandom_range(0, 1));
    s.ctrl   = 5'($urandom);
    s.pc     = rand64();
    s.se     = ($urandom_range(0, 1) == 1) ? rand64() : 64'($urandom_range(0, 64));
    s.opcode = ($urandom_range(0, 7) == 0) ? 11'($urandom) : ops[$urandom_range(0, 6)];
    s.rd     = 5'($urandom);
    case ($urandom_range(0, 3))
      0: begin s.rd1 = 64'($urandom_range(0, 20)); s.rd2 = 64'($urandom_range(0, 20)); end
      1: begin s.rd1 = rand64(); s.rd2 = rand64(); end
      2: begin s.rd1 = rand64(); s.rd2 = s.rd1; end
      default: begin s.rd1 = '1; s.rd2 = 64'd1; end
    endcase
`ifdef LEGV8_MUL_EN
    if (s.aluOp == 2'b10 && s.opcode == OpMul) s.opcode = OpSub;
`endif
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    ex.ALUOp_s3  = s.aluOp;
    ex.ALUSrc_s3 = s.aluSrc;
    {ex.MemtoReg_s3, ex.RegWrite_s3, ex.MemRead_s3, ex.MemWrite_s3, ex.Branch_s3} = s.ctrl;
    ex.PC_s3     = s.pc;
    ex.RD1_s3    = s.rd1;
    ex.RD2_s3    = s.rd2;
    ex.SE1out_s3 = s.se;
    ex.Opcode_s3 = s.opcode;
    ex.Ins4_0_s3 = s.rd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input expect_t e, input logic expStall);
    checkValue({tag, " ctrl"}, 64'({ex.MemtoReg_s4, ex.RegWrite_s4, ex.MemRead_s4, ex.MemWrite_s4, ex.Branch_s4}),
               64'(e.ctrl));
    checkValue({tag, " target"}, ex.BranchTarget_s4, e.target);
    checkValue({tag, " result"}, ex.ALUResult_s4, e.result);
    checkValue({tag, " zero"}, 64'(ex.Zero_s4), 64'(e.zero));
    checkValue({tag, " rd2"}, ex.RD2_s4, e.storeData);
    checkValue({tag, " rd"}, 64'(ex.Ins4_0_s4), 64'(e.rd));
    checkValue({tag, " stall"}, 64'(ex.stall), 64'(expStall));
  endtask

  task automatic runSingle(input string tag, input stim_t s);
    applyStimulus(s);
    #1;
    checkValue({tag, " stall before edge"}, 64'(ex.stall), 64'd0);
    tick();
    checkOutput(tag, refModel(s), 1'b0);
  endtask

  initial begin
    stim_t s;
    stim_t addS;

    $display("[TB] reset");
    addS = makeStim(2'b10, 1'b0, 5'b01000, 64'h40, 64'd5, 64'd7, 64'd3, OpAdd, 5'd1);
    applyStimulus(addS);
    tick();
    tick();
    checkOutput("reset", bubble(), 1'b0);
    reset = 1'b0;

    $display("[TB] directed cases");
    runSingle("add", addS);
    checkValue("add is 12", ex.ALUResult_s4, 64'd12);
    runSingle("ldur", makeStim(2'b00, 1'b1, 5'b11100, 64'h80, 64'h100, 64'd9, 64'd8, OpLdur, 5'd2));
    checkValue("ldur is 0x108", ex.ALUResult_s4, 64'h108);
    runSingle("cbz taken", makeStim(2'b01, 1'b0, 5'b00001, 64'h40, 64'd77, 64'd0, 64'd3, OpCbz, 5'd3));
    checkValue("cbz target 0x4C", ex.BranchTarget_s4, 64'h4C);
    checkValue("cbz zero 1", 64'(ex.Zero_s4), 64'd1);
    runSingle("cbz not taken", makeStim(2'b01, 1'b0, 5'b00001, 64'h40, 64'd77, 64'd1, 64'd3, OpCbz, 5'd3));
    checkValue("cbz zero 0", 64'(ex.Zero_s4), 64'd0);
    runSingle("sub wrap", makeStim(2'b10, 1'b0, 5'b01000, 64'h0, 64'd0, 64'd1, 64'd0, OpSub, 5'd4));
    checkValue("sub wrap all ones", ex.ALUResult_s4, 64'hFFFF_FFFF_FFFF_FFFF);
    runSingle("sub equal", makeStim(2'b10, 1'b0, 5'b01000, 64'h0, 64'd99, 64'd99, 64'd0, OpSub, 5'd5));
    checkValue("sub equal zero", 64'(ex.Zero_s4), 64'd1);
    runSingle("branch wrap", makeStim(2'b01, 1'b0, 5'b00001, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd2,
                                      64'd8, OpCbz, 5'd6));

`ifdef LEGV8_MUL_EN
    $display("[TB] multiply 6 x 7");
    s = makeStim(2'b10, 1'b0, 5'b01000, 64'h200, 64'd6, 64'd7, 64'd1, OpMul, 5'd9);
    applyStimulus(s);
    #1;
    checkValue("mul present stall", 64'(ex.stall), 64'd1);
    for (int i = 1; i <= 64; i++) begin
      tick();
      checkOutput($sformatf("mul bubble %0d", i), bubble(), (i < 64));
      if (i == 20) applyStimulus(randomStim());
      if (i == 64) applyStimulus(addS);
    end
    tick();
    checkOutput("mul 6x7", refModel(s), 1'b0);
    checkValue("mul is 42", ex.ALUResult_s4, 64'd42);
    tick();
    checkOutput("add after mul", refModel(addS), 1'b0);

    $display("[TB] random multiply, back-to-back, reset mid-multiply");
    s = makeStim(2'b10, 1'b0, 5'b01000, rand64(), rand64(), rand64(), rand64(), OpMul, 5'($urandom));
    applyStimulus(s);
    for (int i = 1; i <= 64; i++) tick();
    checkValue("mul last cycle stall", 64'(ex.stall), 64'd0);
    tick();
    checkOutput("mul random", refModel(s), 1'b1);
    for (int i = 0; i < 21; i++) tick();
    checkValue("second mul busy stall", 64'(ex.stall), 64'd1);
    reset = 1'b1;
    applyStimulus(addS);
    tick();
    checkOutput("reset mid mul", bubble(), 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("add after reset", refModel(addS), 1'b0);
`else
    $display("[TB] unsupported multiply");
    s = makeStim(2'b10, 1'b0, 5'b01000, 64'h200, 64'd6, 64'd7, 64'd1, OpMul, 5'd9);
    runSingle("mul unsupported", s);
    checkValue("mul unsupported zero", 64'(ex.Zero_s4), 64'd1);
    reset = 1'b1;
    applyStimulus(randomStim());
    tick();
    checkOutput("reset after ops", bubble(), 1'b0);
    reset = 1'b0;
    runSingle("add after reset", addS);
`endif

    $display("[TB] randomized ops");
    for (int i = 0; i < 60; i++) begin
      runSingle($sformatf("rand %0d", i), randomStim());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
